// File: rtl/fwht_pkg.sv
// Shared definitions for the FWHT output stream sink: framing FSM states
// and the completed-frame counter width.
package fwht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DISCARD = 2'd2
    } fwht_state_e;

    localparam int FRAME_CNT_W = 16;

endpackage : fwht_pkg

// File: rtl/fwht_stream_sink_if.sv
// Stream bundle around the sink: upstream transform beats in, buffered beats out.
interface fwht_stream_sink_if #(
    parameter int WIDTH = 512
);
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    // master: the environment (producer upstream, consumer downstream)
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    // slave: the sink itself
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface : fwht_stream_sink_if

// File: rtl/fwht_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// The head entry is visible combinationally; reads as zero while empty.
module fwht_sync_fifo #(
    parameter int DW         = 9,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_wr, do_rd;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        do_rd = rd_en && !empty;
        // a pop frees the slot the write lands in, so full+pop still writes
        do_wr = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data  = empty ? '0 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule : fwht_sync_fifo

// File: rtl/fwht_stream_sink.sv
// Buffers a never-stalling transform stream, tags frame ends, and discards
// the remainder of any frame that loses a beat to a full buffer.
module fwht_stream_sink
    import fwht_pkg::*;
#(
    parameter int WIDTH      = 512,
    parameter int L_WIDTH    = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    fwht_stream_sink_if.slave      axis,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam logic [L_WIDTH-1:0] LAST_BEAT = '1;

    fwht_state_e            state_q, state_d;
    logic [L_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
    logic                   overflow_q, overflow_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             fifo_full, fifo_empty;
    logic [WIDTH:0]   fifo_rd_data;
    logic             pop, can_store, tlast_tag, accept, drop;

    always_comb begin
        pop       = !fifo_empty && axis.m_axis_tready;
        can_store = !fifo_full || pop;
        tlast_tag = (beat_cnt_q == LAST_BEAT);
        accept    = axis.s_axis_tvalid && (state_q != ST_DISCARD) && can_store;
        drop      = axis.s_axis_tvalid && !accept;
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        overflow_d  = overflow_q || drop;
        frame_cnt_d = frame_cnt_q;

        if (axis.s_axis_tvalid) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (accept && tlast_tag) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            // a frame that ends (stored or dropped) always returns to IDLE,
            // so a loss on the last beat never poisons the following frame
            unique case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (tlast_tag)  state_d = ST_IDLE;
                    else if (drop)  state_d = ST_DISCARD;
                    else            state_d = ST_RUN;
                end
                ST_DISCARD: begin
                    if (tlast_tag)  state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fwht_sync_fifo #(
        .DW         (WIDTH + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .wr_en   (accept),
        .wr_data ({tlast_tag, axis.s_axis_tdata}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        axis.s_axis_tready = can_store;
        axis.m_axis_tvalid = !fifo_empty;
        axis.m_axis_tdata  = fifo_rd_data[WIDTH-1:0];
        axis.m_axis_tlast  = fifo_rd_data[WIDTH];
        overflow           = overflow_q;
        frame_cnt          = frame_cnt_q;
    end

endmodule : fwht_stream_sink

// File: tb/tb_fwht_stream_sink.sv
// Scoreboard bench for fwht_stream_sink (WIDTH=8, L_WIDTH=3, DEPTH_LOG2=2).
module tb_fwht_stream_sink;
    import fwht_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic overflow;
    logic [15:0] frame_cnt;

    fwht_stream_sink_if #(.WIDTH(W)) axis_if ();

    fwht_stream_sink #(
        .WIDTH      (W),
        .L_WIDTH    (3),
        .DEPTH_LOG2 (2)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .axis      (axis_if),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // reference model, evaluated at negedge for the following posedge
    logic [8:0]  sb_q[$];
    fwht_state_e m_state  = ST_IDLE;
    logic [2:0]  m_beat   = '0;
    logic        m_ovf    = 1'b0;
    logic [15:0] m_frames = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            sb_q.delete();
            m_state = ST_IDLE; m_beat = '0; m_ovf = 1'b0; m_frames = '0;
            prev_stall = 1'b0;
            check("rst_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
            check("rst_tlast", 32'(axis_if.m_axis_tlast), 32'd0);
            check("rst_tdata", 32'(axis_if.m_axis_tdata), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        end else begin
            logic pop, can, tl;
            check("tvalid", 32'(axis_if.m_axis_tvalid), 32'(sb_q.size() > 0));
            if (sb_q.size() > 0) begin
                check("tdata", 32'(axis_if.m_axis_tdata), 32'(sb_q[0][7:0]));
                check("tlast", 32'(axis_if.m_axis_tlast), 32'(sb_q[0][8]));
            end
            if (prev_stall) begin
                check("stall_tvalid", 32'(axis_if.m_axis_tvalid), 32'd1);
                check("stall_tdata", 32'(axis_if.m_axis_tdata), 32'(prev_data));
            end
            pop = (sb_q.size() > 0) && axis_if.m_axis_tready;
            can = (sb_q.size() < DEPTH) || pop;
            check("s_tready", 32'(axis_if.s_axis_tready), 32'(can));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            check("state", 32'(dut.state_q), 32'(m_state));
            prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
            prev_data  = axis_if.m_axis_tdata;

            if (pop) void'(sb_q.pop_front());
            if (axis_if.s_axis_tvalid) begin
                tl = (m_beat == 3'd7);
                if (m_state != ST_DISCARD && can) begin
                    sb_q.push_back({tl, axis_if.s_axis_tdata});
                    if (tl) m_frames++;
                    m_state = tl ? ST_IDLE : ST_RUN;
                end else begin
                    m_ovf = 1'b1;
                    if (tl) m_state = ST_IDLE;
                    else    m_state = ST_DISCARD;
                end
                m_beat++;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        axis_if.s_axis_tdata  = d;
        axis_if.s_axis_tvalid = 1'b1;
        tick();
        axis_if.s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        axis_if.s_axis_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.m_axis_tready = 1'b0;
        repeat (2) tick();
        ARESETN = 1'b1;
        tick();
    endtask

    initial begin
        axis_if.s_axis_tdata  = '0;
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.m_axis_tready = 1'b0;
        repeat (3) tick();
        ARESETN = 1'b1;
        tick();

        // single frame, free-flowing output
        axis_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        idle(3);
        check("s1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("s1_overflow", 32'(overflow), 32'd0);

        // stalled output: fifth beat overflows, rest of frame discarded
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
        check("s2_discard", 32'(dut.state_q), 32'(ST_DISCARD));
        check("s2_overflow", 32'(overflow), 32'd1);
        for (int i = 5; i < 8; i++) send(8'h20 + 8'(i));
        axis_if.m_axis_tready = 1'b1;
        idle(6);
        check("s2_frame_cnt", 32'(frame_cnt), 32'd0);
        check("s2_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
        axis_if.m_axis_tready = 1'b1;
        axis_if.s_axis_tdata  = 8'h44;
        axis_if.s_axis_tvalid = 1'b1;
        #1;
        check("s3_s_tready", 32'(axis_if.s_axis_tready), 32'd1);
        tick();
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.m_axis_tready = 1'b0;
        #1;
        check("s3_occupancy", 32'(dut.u_fifo.wr_ptr_q - dut.u_fifo.rd_ptr_q), 32'd4);
        check("s3_overflow", 32'(overflow), 32'd0);
        tick();
        axis_if.m_axis_tready = 1'b1;
        for (int i = 5; i < 8; i++) send(8'h40 + 8'(i));
        idle(6);
        check("s3_frame_cnt", 32'(frame_cnt), 32'd1);

        // two back-to-back frames
        do_reset();
        axis_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i));
        idle(3);
        check("s4_frame_cnt", 32'(frame_cnt), 32'd2);
        check("s4_overflow", 32'(overflow), 32'd0);

        // reset mid-frame with the input still active
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        axis_if.s_axis_tdata  = 8'h54;
        axis_if.s_axis_tvalid = 1'b1;
        ARESETN = 1'b0;
        #1;
        check("s5_rst_tvalid", 32'(axis_if.m_axis_tvalid), 32'd0);
        repeat (2) tick();
        axis_if.s_axis_tvalid = 1'b0;
        ARESETN = 1'b1;
        tick();
        axis_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        idle(3);
        check("s5_frame_cnt", 32'(frame_cnt), 32'd1);

        // random backpressure with input gaps; input only offered when space exists
        do_reset();
        begin
            int sent = 0;
            int guard = 0;
            while (sent < 24 && guard < 2000) begin
                axis_if.m_axis_tready = 1'($urandom_range(0, 1));
                if (sb_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                    axis_if.s_axis_tdata  = 8'($urandom);
                    axis_if.s_axis_tvalid = 1'b1;
                    sent++;
                end else begin
                    axis_if.s_axis_tvalid = 1'b0;
                end
                tick();
                guard++;
            end
            check("s6_all_sent", 32'(sent), 32'd24);
        end
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.m_axis_tready = 1'b1;
        idle(8);
        check("s6_drained", 32'(axis_if.m_axis_tvalid), 32'd0);
        check("s6_overflow", 32'(overflow), 32'd0);
        check("s6_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fwht_stream_sink
